// File: rtl/demux_large_ds.sv
// -----------------------------------------------------------------------------
// demux_large_ds
//
// Ten-lane byte distributor. One 8-bit beat per cycle arrives on a
// valid/ready input together with a 4-bit lane select. The beat is steered
// into one of ten one-entry lane holding registers (lane 0 = block_a ...
// lane 9 = block_j), and each lane drains through its own valid/ready port.
//
// Handshake rule used on every port of this block: a transfer happens on a
// rising clock edge where valid and ready are both 1. A producer holds valid
// (and its data) until that edge. Ready never depends combinationally on the
// valid of the same port.
//
// Build option (macro DEMUX_OOR_DROP_EN):
//   undefined : a select of 10..15 targets lane 0, mirroring the selector's
//               default-to-block_a rule. Port oor_count does not exist.
//   defined   : an out-of-range beat is always accepted and then discarded.
//               It still counts in beat_count and also bumps the saturating
//               oor_count.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous reset, active high
//   in_valid    in   1   input beat present
//   in_ready    out  1   input beat can be accepted this cycle
//   in_data     in   8   input byte
//   in_sel      in   4   target lane (10..15 out of range)
//   out_valid   out  10  bit k: lane k holds a beat
//   out_ready   in   10  bit k: lane k consumer takes the beat this cycle
//   out_data    out  80  lane k byte at [8k+7:8k]
//   beat_count  out  16  accepted input beats, wraps at 16 bits
//   oor_count   out  8   out-of-range beats, saturating (DEMUX_OOR_DROP_EN only)
// -----------------------------------------------------------------------------
module demux_large_ds (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [3:0]  in_sel,
    output logic [9:0]  out_valid,
    input  logic [9:0]  out_ready,
    output logic [79:0] out_data,
    output logic [15:0] beat_count
`ifdef DEMUX_OOR_DROP_EN
    ,
    output logic [7:0]  oor_count
`endif
);

    localparam int unsigned NUM_LANES = 10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0]  valid_q, valid_d;
    logic [79:0] data_q,  data_d;
    logic [15:0] beat_count_q, beat_count_d;

    // ------------------------------------------------------------------
    // Lane targeting
    // ------------------------------------------------------------------
    logic       in_range;
    logic       drop_beat;   // out-of-range beat that is consumed but not stored
    logic [9:0] tgt_oh;      // one-hot target lane, all zero for a dropped beat
    logic [9:0] lane_free;   // lane can take a beat this cycle
    logic       accept;
    logic [9:0] load;
    logic [9:0] pop;

    assign in_range = (in_sel < 4'd10);

`ifdef DEMUX_OOR_DROP_EN
    assign drop_beat = ~in_range;
`else
    assign drop_beat = 1'b0;
`endif

    always_comb begin
        tgt_oh = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (in_sel == 4'(k)) begin
                tgt_oh[k] = 1'b1;
            end
        end
`ifndef DEMUX_OOR_DROP_EN
        // Out-of-range selects fall back to lane 0 (block_a).
        if (!in_range) begin
            tgt_oh[0] = 1'b1;
        end
`endif
    end

    // A full lane can still take a beat in the same cycle it pops, so a
    // blocked beat waits only on its own lane's consumer.
    assign lane_free = ~valid_q | out_ready;

    // in_ready depends on in_sel and out_ready (and lane state) only.
    // During reset valid_q is zero, so in_ready reads 1.
    assign in_ready = drop_beat | (|(tgt_oh & lane_free));

    assign accept = in_valid & in_ready;
    assign load   = accept ? tgt_oh : 10'd0;
    assign pop    = valid_q & out_ready;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        // A load in the same cycle as a pop wins, so the lane stays full
        // with no bubble.
        valid_d = (valid_q & ~pop) | load;
        data_d  = data_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (load[k]) begin
                data_d[8*k +: 8] = in_data;
            end
        end
        beat_count_d = beat_count_q + 16'(accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            beat_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            beat_count_q <= beat_count_d;
        end
    end

`ifdef DEMUX_OOR_DROP_EN
    logic [7:0] oor_count_q, oor_count_d;

    always_comb begin
        oor_count_d = oor_count_q;
        if (accept && drop_beat && (oor_count_q != 8'hFF)) begin
            oor_count_d = oor_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_count_q <= '0;
        end else begin
            oor_count_q <= oor_count_d;
        end
    end

    assign oor_count = oor_count_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign beat_count = beat_count_q;

endmodule
